stack_level_ctrl: RTL and testbench
===================================

# stack_level_ctrl

Game-progress controller for the stacker: debounces the player's stop button and runs the IDLE/PLAY/WAIT/WON/LOST state machine. It handshakes each stop with the row-placement logic, and tracks the current level. It drives the 4-bit level consumed directly by the score display stage, plus a per-level row-movement tick. Sits between the button pin / placement logic and the seven-segment score display.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz)
- BASE_PERIOD, 20_000_000, move_tick period in cycles at level 0; period at level L is BASE_PERIOD >> L
- MAX_LEVEL, 7, winning level (1..15); the display stage shows 0..7
- WAIT_TIMEOUT, 16, cycles to wait for place_valid after stop_pulse
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- btn_in  in  1  raw asynchronous stop/start button, active-high
- place_valid  in  1  one-cycle strobe from placement logic: result of the last stop
- place_hit  in  1  qualified by place_valid; 1 = block overlapped, 0 = miss
- stop_pulse  out  1  one-cycle request to placement logic to freeze the row
- move_tick  out  1  one-cycle row-advance strobe, PLAY only
- level  out  4  current level, to score display
- game_won  out  1  high in WON
- game_over  out  1  high in LOST

## Operation
- Button path: 2-flop synchronizer, then debounce counter; debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples differing from it; counter clears on any mismatch. press = rising edge of debounced level (one cycle).
- IDLE: level=0. press -> PLAY.
- PLAY: move_tick active. press -> stop_pulse, go WAIT.
- WAIT: press ignored, move_tick held 0. place_valid&place_hit: if level==MAX_LEVEL -> WON (level unchanged), else level+1 -> PLAY. place_valid&!place_hit -> LOST. No place_valid within WAIT_TIMEOUT cycles -> LOST.
- WON/LOST: level held; press -> IDLE (level cleared to 0).
- place_valid outside WAIT ignored. place_valid on the timeout-expiry cycle: place_valid wins.
- move_tick counter: clears on entry to PLAY and on every level change; tick when count == (BASE_PERIOD>>level)-1, then wraps to 0. Shifted period has a floor of 1 (tick every cycle).
- level saturates at MAX_LEVEL; never wraps.

## Timing
- Reset: state IDLE, level 0, stop_pulse 0, move_tick 0, game_won 0, game_over 0. Synchronizer, debounced level, and all counters 0.
- btn_in rise to press: 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle.
- stop_pulse registered: high exactly one cycle, the cycle after press, coincident with state==WAIT.
- level, game_won, and game_over update the cycle after place_valid (or timeout) is sampled.
- Reset asserted mid-game (any state) returns everything to reset values on the next edge. An outstanding place_valid after reset is ignored.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package stacker_pkg: state enum (IDLE, PLAY, WAIT, WON, LOST, 3-bit encoding), LEVEL_W=4 constant.
- Sub-module button_debounce (synchronizer + debounce counter + rising-edge press output), parameterized by DEBOUNCE_CYCLES. It is reused later for other board buttons.
- Top holds FSM, level register, WAIT timer, move_tick divider.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BASE_PERIOD=64, WAIT_TIMEOUT=16.
- Bounce: btn_in toggles every 2 cycles for 20 cycles, then held high -> exactly one press. State IDLE->PLAY 2+4+1 cycles after final rise.
- Full win: 8 stops each answered with place_valid&place_hit 3 cycles after stop_pulse -> level 0..7 increments by 1 each time. Eighth hit -> game_won=1, level=7.
- Miss: at level 3, place_valid&!place_hit -> game_over=1, level stays 3. Next press -> IDLE, level=0.
- Timeout: no place_valid for 16 cycles after stop_pulse -> LOST. Also, place_valid&hit on the 16th cycle -> level+1, PLAY.
- move_tick: level 0 -> period 64; level 2 -> period 16. No ticks in WAIT/IDLE, and counter restarts after level change.
- Reset asserted in WAIT with level=5 -> all outputs 0 next cycle. A place_valid one cycle later causes no change.

Source files
------------

// File: rtl/stacker_pkg.sv
// -----------------------------------------------------------------------------
// stacker_pkg
// Shared definitions for the stacker game-progress logic.
//   state_t  : game state machine states, 3-bit encoding
//   LEVEL_W  : width of the level value sent to the score display
// -----------------------------------------------------------------------------
package stacker_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        WAIT = 3'd2,
        WON  = 3'd3,
        LOST = 3'd4
    } state_t;

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes a raw asynchronous button and filters contact bounce. The
// filtered level only changes after DEBOUNCE_CYCLES consecutive synchronized
// samples that all disagree with it. A one-cycle press strobe marks each
// rising edge of the filtered level.
//
// Ports:
//   i_clock  : system clock, all logic on posedge
//   i_reset  : synchronous active-high reset
//   i_btn    : raw asynchronous button, active-high
//   o_press  : one-cycle strobe on each accepted press
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_debounced;
    logic          r_debouncedPrev;
    logic [CW-1:0] r_count;

    // Two-flop synchronizer brings the button into the clock domain before
    // anything looks at it. The debounce counter then counts how many
    // synchronized samples in a row disagree with the accepted level; any
    // agreeing sample throws the run away. When the run reaches the required
    // length the accepted level follows the input and the count starts over.
    // The previous accepted level is kept so the press edge can be formed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_debounced     <= 1'b0;
            r_debouncedPrev <= 1'b0;
            r_count         <= '0;
        end else begin
            r_sync1         <= i_btn;
            r_sync2         <= r_sync1;
            r_debouncedPrev <= r_debounced;
            if (r_sync2 == r_debounced) begin
                r_count <= '0;
            end else if (r_count == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_debounced <= r_sync2;
                r_count     <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Press is built purely from two flops, so it is glitch-free and lasts
    // exactly one cycle per accepted rising edge.
    assign o_press = r_debounced & ~r_debouncedPrev;

endmodule

// File: rtl/stack_level_ctrl.sv
// -----------------------------------------------------------------------------
// stack_level_ctrl
// Game-progress controller for the stacker. Debounces the stop button, runs
// the IDLE/PLAY/WAIT/WON/LOST state machine, handshakes each stop with the
// row-placement logic, tracks the current level and generates the
// level-dependent row-movement tick.
//
// Ports:
//   i_clock       : system clock, all logic on posedge
//   i_reset       : synchronous active-high reset
//   i_btn_in      : raw asynchronous stop/start button, active-high
//   i_place_valid : one-cycle strobe, result of the last stop is available
//   i_place_hit   : qualified by i_place_valid; 1 = overlap, 0 = miss
//   o_stop_pulse  : one-cycle request to freeze the moving row
//   o_move_tick   : one-cycle row-advance strobe, only while playing
//   o_level       : current level for the score display
//   o_game_won    : high while the game is won
//   o_game_over   : high while the game is lost
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module stack_level_ctrl
    import stacker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_PERIOD     = 20_000_000,
    parameter int MAX_LEVEL       = 7,
    parameter int WAIT_TIMEOUT    = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_btn_in,
    input  logic               i_place_valid,
    input  logic               i_place_hit,
    output logic               o_stop_pulse,
    output logic               o_move_tick,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_game_won,
    output logic               o_game_over
);

    localparam int PW = $clog2(BASE_PERIOD + 1);
    localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    state_t             r_state;
    state_t             w_nextState;
    logic [LEVEL_W-1:0] r_level;
    logic               r_stopPulse;
    logic               r_moveTick;
    logic               r_gameWon;
    logic               r_gameOver;
    logic [PW-1:0]      r_moveCnt;
    logic [WW-1:0]      r_waitCnt;

    logic               w_press;
    logic               w_atMax;
    logic               w_waitExpired;
    logic [PW-1:0]      w_period;
    logic [LEVEL_W-1:0] w_levelNext;
    logic               w_stopPulseNext;
    logic               w_moveTickNext;
    logic               w_gameWonNext;
    logic               w_gameOverNext;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_btn   (i_btn_in),
        .o_press (w_press)
    );

    assign w_atMax       = (r_level == LEVEL_W'(MAX_LEVEL));
    assign w_waitExpired = (r_waitCnt == WW'(WAIT_TIMEOUT - 1));

    // Row speed doubles with every level. Once the shift runs out of bits the
    // period is held at one cycle so the row still moves every clock.
    always_comb begin
        w_period = PW'(BASE_PERIOD) >> r_level;
        if (w_period == '0) begin
            w_period = PW'(1);
        end
    end

    // State register. Reset from any state lands in IDLE on the next edge,
    // which also makes any placement result still in flight irrelevant.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A placement result is only meaningful while waiting
    // for one, and it takes priority over the timeout when both land on the
    // same cycle. A hit on the top level ends the game as a win instead of
    // climbing further.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_nextState = PLAY;
                end
            end
            PLAY: begin
                if (w_press) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (i_place_valid) begin
                    if (!i_place_hit) begin
                        w_nextState = LOST;
                    end else if (w_atMax) begin
                        w_nextState = WON;
                    end else begin
                        w_nextState = PLAY;
                    end
                end else if (w_waitExpired) begin
                    w_nextState = LOST;
                end
            end
            WON, LOST: begin
                if (w_press) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic, computed one cycle ahead so every output can be
    // registered. The stop request coincides with the first WAIT cycle.
    // The movement tick is suppressed on the cycle the game leaves PLAY so
    // no tick ever shows up during WAIT. The level only climbs on a
    // successful placement below the top level and is cleared when a
    // finished game is dismissed.
    always_comb begin
        w_stopPulseNext = 1'b0;
        w_moveTickNext  = 1'b0;
        w_levelNext     = r_level;
        w_gameWonNext   = (w_nextState == WON);
        w_gameOverNext  = (w_nextState == LOST);

        if (r_state == PLAY && w_press) begin
            w_stopPulseNext = 1'b1;
        end

        if (r_state == PLAY && w_nextState == PLAY &&
            r_moveCnt == w_period - PW'(1)) begin
            w_moveTickNext = 1'b1;
        end

        if (r_state == WAIT && i_place_valid && i_place_hit && !w_atMax) begin
            w_levelNext = r_level + LEVEL_W'(1);
        end else if ((r_state == WON || r_state == LOST) && w_press) begin
            w_levelNext = '0;
        end
    end

    // Output registers and the level register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_level     <= '0;
            r_stopPulse <= 1'b0;
            r_moveTick  <= 1'b0;
            r_gameWon   <= 1'b0;
            r_gameOver  <= 1'b0;
        end else begin
            r_level     <= w_levelNext;
            r_stopPulse <= w_stopPulseNext;
            r_moveTick  <= w_moveTickNext;
            r_gameWon   <= w_gameWonNext;
            r_gameOver  <= w_gameOverNext;
        end
    end

    // Movement divider. It only runs while staying in PLAY, so it restarts
    // from zero on every entry to PLAY; a level change also restarts it so a
    // faster row never inherits a partial count from the slower one.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_moveCnt <= '0;
        end else if (r_state == PLAY && w_nextState == PLAY &&
                     w_levelNext == r_level) begin
            if (r_moveCnt == w_period - PW'(1)) begin
                r_moveCnt <= '0;
            end else begin
                r_moveCnt <= r_moveCnt + PW'(1);
            end
        end else begin
            r_moveCnt <= '0;
        end
    end

    // Placement watchdog. Counts the cycles spent waiting for a result and
    // is cleared whenever the game is not sitting in WAIT.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_waitCnt <= '0;
        end else if (r_state == WAIT && w_nextState == WAIT) begin
            r_waitCnt <= r_waitCnt + WW'(1);
        end else begin
            r_waitCnt <= '0;
        end
    end

    assign o_stop_pulse = r_stopPulse;
    assign o_move_tick  = r_moveTick;
    assign o_level      = r_level;
    assign o_game_won   = r_gameWon;
    assign o_game_over  = r_gameOver;

endmodule

// File: tb/tb_stack_level_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_level_ctrl
// Directed self-checking bench for stack_level_ctrl with small timing
// parameters. A behavioural game model tracks what every output must be
// and is compared against the design on every falling clock edge; directed
// literal expectations pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_stack_level_ctrl;

    localparam int DEB  = 4;
    localparam int BASE = 64;
    localparam int MAXL = 7;
    localparam int TMO  = 16;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_WAIT = 2;
    localparam int M_WON  = 3;
    localparam int M_LOST = 4;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       btnIn      = 1'b0;
    logic       placeValid = 1'b0;
    logic       placeHit   = 1'b0;
    logic       stopPulse;
    logic       moveTick;
    logic [3:0] level;
    logic       gameWon;
    logic       gameOver;

    int checks   = 0;
    int failures = 0;

    int mState, mLevel, mStop, mTick, mWon, mOver;
    int mEdge, mEntry, mWaitStart;
    int mSync1, mSync2, mDeb, mPress;
    int mRun[$];
    bit mValid = 1'b0;

    stack_level_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BASE_PERIOD     (BASE),
        .MAX_LEVEL       (MAXL),
        .WAIT_TIMEOUT    (TMO)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_btn_in      (btnIn),
        .i_place_valid (placeValid),
        .i_place_hit   (placeHit),
        .o_stop_pulse  (stopPulse),
        .o_move_tick   (moveTick),
        .o_level       (level),
        .o_game_won    (gameWon),
        .o_game_over   (gameOver)
    );

    // Free-running 100 MHz style clock.
    always #5 clock = ~clock;

    // Single comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one input pattern for n cycles; inputs change 1 ns after the
    // rising edge so they are stable when the design samples them.
    task automatic applyStimulus(input logic btn, input logic pv, input logic ph, input int n);
        btnIn      = btn;
        placeValid = pv;
        placeHit   = ph;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advances the behavioural game model by one rising edge, using the
    // inputs that edge will sample. The button filter is modelled as a two
    // cycle delay followed by "the last DEB samples all disagree with the
    // accepted level".
    task automatic modelStep();
        int sample;
        int newDeb;
        int pressNow;
        int period;
        if (reset) begin
            mState = M_IDLE; mLevel = 0; mStop = 0; mTick = 0; mWon = 0; mOver = 0;
            mSync1 = 0; mSync2 = 0; mDeb = 0; mPress = 0;
            mRun.delete();
            mEdge = 0; mEntry = 0; mWaitStart = 0;
            mValid = 1'b1;
            return;
        end
        mEdge++;
        pressNow = mPress;
        sample   = mSync2;
        mSync2   = mSync1;
        mSync1   = int'(btnIn);
        newDeb   = mDeb;
        if (sample == mDeb) begin
            mRun.delete();
        end else begin
            mRun.push_back(sample);
            if (mRun.size() == DEB) begin
                newDeb = sample;
                mRun.delete();
            end
        end
        mPress = (newDeb == 1 && mDeb == 0) ? 1 : 0;
        mDeb   = newDeb;

        mStop = 0;
        mTick = 0;
        case (mState)
            M_IDLE: begin
                if (pressNow == 1) begin
                    mState = M_PLAY;
                    mEntry = mEdge;
                end
            end
            M_PLAY: begin
                if (pressNow == 1) begin
                    mState     = M_WAIT;
                    mStop      = 1;
                    mWaitStart = mEdge;
                end else begin
                    period = BASE >> mLevel;
                    if (period < 1) period = 1;
                    if ((mEdge - mEntry) % period == 0) mTick = 1;
                end
            end
            M_WAIT: begin
                if (placeValid) begin
                    if (!placeHit) begin
                        mState = M_LOST;
                    end else if (mLevel == MAXL) begin
                        mState = M_WON;
                    end else begin
                        mLevel = mLevel + 1;
                        mState = M_PLAY;
                        mEntry = mEdge;
                    end
                end else if (mEdge - mWaitStart == TMO) begin
                    mState = M_LOST;
                end
            end
            default: begin
                if (pressNow == 1) begin
                    mState = M_IDLE;
                    mLevel = 0;
                end
            end
        endcase
        mWon  = (mState == M_WON)  ? 1 : 0;
        mOver = (mState == M_LOST) ? 1 : 0;
    endtask

    // Every falling edge: compare the design against the model state for the
    // edge just taken, then step the model for the coming edge.
    always @(negedge clock) begin
        if (mValid) begin
            checkOutput("cyc_stop_pulse", 32'(stopPulse), 32'(mStop));
            checkOutput("cyc_move_tick",  32'(moveTick),  32'(mTick));
            checkOutput("cyc_level",      32'(level),     32'(mLevel));
            checkOutput("cyc_game_won",   32'(gameWon),   32'(mWon));
            checkOutput("cyc_game_over",  32'(gameOver),  32'(mOver));
        end
        modelStep();
    end

    // Holds the button where it is and counts cycles until the next move
    // tick; a missing tick within the budget reports -1.
    task automatic waitTick(input string name, input int expected, input int budget);
        int  n    = 0;
        bit  seen = 1'b0;
        while (n < budget && !seen) begin
            applyStimulus(btnIn, 1'b0, 1'b0, 1);
            n++;
            if (moveTick === 1'b1) seen = 1'b1;
        end
        if (!seen) n = -1;
        checkOutput(name, 32'(n), 32'(expected));
    endtask

    task automatic releaseBtn();
        applyStimulus(1'b0, 1'b0, 1'b0, 7);
    endtask

    task automatic doPress();
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        releaseBtn();
    endtask

    // Press stop, then answer the placement three cycles after stop_pulse.
    task automatic stopAndAnswer(input logic hit);
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        checkOutput("lit_stop_pulse", 32'(stopPulse), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, hit, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("rst_level",     32'(level),     32'd0);
        checkOutput("rst_stop",      32'(stopPulse), 32'd0);
        checkOutput("rst_tick",      32'(moveTick),  32'd0);
        checkOutput("rst_won",       32'(gameWon),   32'd0);
        checkOutput("rst_over",      32'(gameOver),  32'd0);
        reset = 1'b0;

        $display("[TB] bouncing button then final press");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2) == 0, 1'b0, 1'b0, 2);
        end
        btnIn = 1'b1;
        waitTick("bounce_first_tick", 71, 200);
        waitTick("lvl0_period", 64, 200);
        releaseBtn();

        $display("[TB] full win");
        for (int i = 0; i < 8; i++) begin
            stopAndAnswer(1'b1);
            checkOutput("win_level", 32'(level), (i < 7) ? 32'(i + 1) : 32'd7);
            if (i == 1) begin
                waitTick("lvl2_restart", 16, 200);
                waitTick("lvl2_period", 16, 200);
            end
            releaseBtn();
        end
        checkOutput("win_flag",  32'(gameWon), 32'd1);
        checkOutput("win_final", 32'(level),   32'd7);
        doPress();
        checkOutput("win_clear_level", 32'(level),   32'd0);
        checkOutput("win_clear_flag",  32'(gameWon), 32'd0);

        $display("[TB] miss at level 3");
        doPress();
        for (int i = 0; i < 3; i++) begin
            stopAndAnswer(1'b1);
            releaseBtn();
        end
        checkOutput("miss_pre_level", 32'(level), 32'd3);
        stopAndAnswer(1'b0);
        checkOutput("miss_over",  32'(gameOver), 32'd1);
        checkOutput("miss_level", 32'(level),    32'd3);
        releaseBtn();
        doPress();
        checkOutput("miss_clear_level", 32'(level),    32'd0);
        checkOutput("miss_clear_over",  32'(gameOver), 32'd0);

        $display("[TB] placement timeout");
        doPress();
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        checkOutput("tmo_stop", 32'(stopPulse), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 15);
        checkOutput("tmo_not_yet", 32'(gameOver), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("tmo_over", 32'(gameOver), 32'd1);
        releaseBtn();
        doPress();
        checkOutput("tmo_clear", 32'(gameOver), 32'd0);

        $display("[TB] hit on the timeout cycle");
        doPress();
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        applyStimulus(1'b1, 1'b0, 1'b0, 15);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("edge_level", 32'(level),    32'd1);
        checkOutput("edge_over",  32'(gameOver), 32'd0);
        releaseBtn();

        $display("[TB] reset while waiting at level 5");
        for (int i = 0; i < 4; i++) begin
            stopAndAnswer(1'b1);
            releaseBtn();
        end
        checkOutput("rw_pre_level", 32'(level), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        checkOutput("rw_stop", 32'(stopPulse), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("rw_level", 32'(level),     32'd0);
        checkOutput("rw_stop0", 32'(stopPulse), 32'd0);
        checkOutput("rw_tick",  32'(moveTick),  32'd0);
        checkOutput("rw_won",   32'(gameWon),   32'd0);
        checkOutput("rw_over",  32'(gameOver),  32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("rw_late_level", 32'(level),    32'd0);
        checkOutput("rw_late_won",   32'(gameWon),  32'd0);
        checkOutput("rw_late_over",  32'(gameOver), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
